// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and helpers for the hazard scoreboard.
//   entry_t      : one shadow-pipeline slot {valid, rd, reg_write, mem_read}
//   ex_src_t     : source operands of the instruction currently in EX
//   SEL_NONE     : forwarding select value meaning "use the ID/EX register"
//   params_legal : elaboration-time legality check of the top parameters
//   stage_hit    : "entry writes a non-zero register that this source reads"
// Register addresses are stored at REG_AW_MAX bits so one struct serves any
// REG_AW; narrower addresses are zero-extended before they are stored or
// compared.
// ---------------------------------------------------------------------------
package hazard_pkg;

  localparam int REG_AW_MAX = 16;
  localparam int SEL_NONE   = 0;

  typedef logic [REG_AW_MAX-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      reg_write;
    logic      mem_read;
  } entry_t;

  typedef struct packed {
    reg_addr_t rs;
    reg_addr_t rt;
    logic      rs_used;
    logic      rt_used;
  } ex_src_t;

  localparam entry_t BUBBLE = '0;

  function automatic bit params_legal(input int reg_aw, input int num_fwd,
                                      input int load_lat);
    return (reg_aw >= 1) && (reg_aw <= REG_AW_MAX) &&
           (num_fwd >= 1) && (load_lat >= 0) && (load_lat < num_fwd);
  endfunction

  // Register $0 is hard-wired to zero, so a writer to it never produces a hit.
  function automatic logic stage_hit(input entry_t e, input reg_addr_t src,
                                     input logic used);
    return e.valid & e.reg_write & (e.rd == src) & (e.rd != '0) & used;
  endfunction

endpackage

// File: rtl/fwd_prio_sel.sv
// ---------------------------------------------------------------------------
// fwd_prio_sel
// Priority encoder for one EX source operand: turns the per-stage match
// vector into a forwarding select, youngest (lowest-numbered) stage first.
//   hit [NUM_FWD-1:0] : bit k-1 set when post-EX stage k holds a matching writer
//   sel [SEL_W-1:0]   : smallest matching k, or SEL_NONE when nothing matches
// ---------------------------------------------------------------------------
module fwd_prio_sel
  import hazard_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic [NUM_FWD-1:0] hit,
  output logic [SEL_W-1:0]   sel
);

  // Scan from the oldest stage down so the youngest match is written last.
  // NOTE: every variable driven in always_comb gets a default on entry;
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    sel = SEL_W'(SEL_NONE);
    for (int k = NUM_FWD; k >= 1; k--) begin
      if (hit[k-1]) sel = SEL_W'(k);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Hazard controller for the pipelined MIPS core. Keeps a shadow pipeline of
// in-flight writers (slot 0 = EX, slot k = post-EX stage k) and derives EX
// forwarding selects, the IF/ID load-use stall and redirect flushes.
//   clk, arst                 : core clock, asynchronous active-high reset
//   enable                    : pipeline advance; low freezes state and counters
//   id_*                      : instruction currently in ID (sources, dest, ctrl)
//   redirect                  : taken branch/jump resolved in MEM this cycle
//   fwd_rs_sel, fwd_rt_sel    : EX operand source (0 = ID/EX value, k = stage k)
//   stall                     : hold PC and IF/ID, bubble into ID/EX
//   flush_ifid, flush_idex    : zero the named pipeline registers
//   stall_cnt, flush_cnt      : saturating event counters
// All outputs are combinational from the current state and inputs.
// ---------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int REG_AW   = 5,
  parameter  int NUM_FWD  = 2,
  parameter  int LOAD_LAT = 1,
  parameter  int CNT_W    = 32,
  localparam int SEL_W    = $clog2(NUM_FWD + 1)
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              enable,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              redirect,
  output logic [SEL_W-1:0]  fwd_rs_sel,
  output logic [SEL_W-1:0]  fwd_rt_sel,
  output logic              stall,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  if (!params_legal(REG_AW, NUM_FWD, LOAD_LAT)) begin : g_bad_params
    $error("hazard_scoreboard: need 1<=REG_AW<=16, NUM_FWD>=1, 0<=LOAD_LAT<NUM_FWD");
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  entry_t  pipe [NUM_FWD+1];
  ex_src_t ex_src;

  // -------------------------------------------------------------------------
  // ID-stage view, widened to the package address width
  // -------------------------------------------------------------------------
  reg_addr_t id_rs_w, id_rt_w;
  entry_t    id_entry;
  ex_src_t   id_src;

  always_comb begin
    id_rs_w  = reg_addr_t'(id_rs);
    id_rt_w  = reg_addr_t'(id_rt);
    id_entry = '{valid: id_valid, rd: reg_addr_t'(id_rd),
                 reg_write: id_reg_write, mem_read: id_mem_read};
    id_src   = '{rs: id_rs_w, rt: id_rt_w,
                 rs_used: id_rs_used, rt_used: id_rt_used};
  end

  // -------------------------------------------------------------------------
  // Forwarding: match the EX sources against post-EX stages 1..NUM_FWD.
  // A bubble in EX reads nothing, so it never forwards.
  // -------------------------------------------------------------------------
  logic [NUM_FWD-1:0] rs_fwd_hit, rt_fwd_hit;

  always_comb begin
    rs_fwd_hit = '0;
    rt_fwd_hit = '0;
    for (int k = 1; k <= NUM_FWD; k++) begin
      rs_fwd_hit[k-1] = pipe[0].valid & stage_hit(pipe[k], ex_src.rs, ex_src.rs_used);
      rt_fwd_hit[k-1] = pipe[0].valid & stage_hit(pipe[k], ex_src.rt, ex_src.rt_used);
    end
  end

  fwd_prio_sel #(.NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_rs_sel (
    .hit (rs_fwd_hit),
    .sel (fwd_rs_sel)
  );

  fwd_prio_sel #(.NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_rt_sel (
    .hit (rt_fwd_hit),
    .sel (fwd_rt_sel)
  );

  // -------------------------------------------------------------------------
  // Load-use: an ID source depends on a load that, by the time ID reaches EX,
  // still will not have reached the first stage it can forward from. Only
  // slots 0..LOAD_LAT-1 are close enough to matter.
  // -------------------------------------------------------------------------
  logic load_use;

  always_comb begin
    load_use = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      load_use = load_use | (pipe[k].mem_read &
                 (stage_hit(pipe[k], id_rs_w, id_rs_used) |
                  stage_hit(pipe[k], id_rt_w, id_rt_used)));
    end
  end

  // The instruction in ID is on the wrong path when a redirect resolves, so
  // stalling for it would be pointless: the redirect takes priority.
  assign stall      = id_valid & ~redirect & load_use;
  assign flush_ifid = redirect;
  assign flush_idex = redirect;

  // -------------------------------------------------------------------------
  // Shadow pipeline advance and event counters
  // -------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // slot shifts from its pre-edge value, independent of statement order.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      // NOTE: the shadow pipeline is a handful of flops, not a RAM, and its
      // valid bits must be clear out of reset, so every slot is reset.
      for (int k = 0; k <= NUM_FWD; k++) pipe[k] <= BUBBLE;
      ex_src    <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (enable) begin
      pipe[0] <= (stall | redirect) ? BUBBLE : id_entry;
      ex_src  <= id_src;
      // The wrong-path instruction in EX is killed as it moves to stage 1.
      pipe[1] <= redirect ? BUBBLE : pipe[0];
      for (int k = 2; k <= NUM_FWD; k++) pipe[k] <= pipe[k-1];

      if (stall && (stall_cnt != '1))    stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
// Directed bench for hazard_scoreboard with NUM_FWD=2 (1 = MEM, 2 = WB),
// LOAD_LAT=1 and a 3-bit counter width so saturation is reachable quickly.
// Inputs are driven just after the falling edge and outputs are checked 1 ns
// later, half a cycle away from the rising edge that advances the state.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

  localparam int REG_AW   = 5;
  localparam int NUM_FWD  = 2;
  localparam int LOAD_LAT = 1;
  localparam int CNT_W    = 3;
  localparam int SEL_W    = $clog2(NUM_FWD + 1);

  logic              clk = 1'b0;
  logic              arst;
  logic              enable;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic              id_rs_used, id_rt_used;
  logic              id_reg_write, id_mem_read;
  logic              redirect;
  logic [SEL_W-1:0]  fwd_rs_sel, fwd_rt_sel;
  logic              stall, flush_ifid, flush_idex;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .REG_AW   (REG_AW),
    .NUM_FWD  (NUM_FWD),
    .LOAD_LAT (LOAD_LAT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .enable       (enable),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rs_used   (id_rs_used),
    .id_rt_used   (id_rt_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .redirect     (redirect),
    .fwd_rs_sel   (fwd_rs_sel),
    .fwd_rt_sel   (fwd_rt_sel),
    .stall        (stall),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Present one instruction in ID.
  task automatic drive_id(input logic v, input logic [REG_AW-1:0] rs,
                          input logic rs_u, input logic [REG_AW-1:0] rt,
                          input logic rt_u, input logic [REG_AW-1:0] rd,
                          input logic rw, input logic mr);
    id_valid     = v;
    id_rs        = rs;
    id_rs_used   = rs_u;
    id_rt        = rt;
    id_rt_used   = rt_u;
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = mr;
  endtask

  task automatic bubble_id();
    drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Advance to the next drive point (one rising edge in between).
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    arst     = 1'b1;
    enable   = 1'b1;
    redirect = 1'b0;
    bubble_id();
    #2;

    // ---- reset state ------------------------------------------------------
    check("rst_rs_sel", 32'(fwd_rs_sel), 0);
    check("rst_rt_sel", 32'(fwd_rt_sel), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_stall_cnt", 32'(stall_cnt), 0);
    check("rst_flush_cnt", 32'(flush_cnt), 0);
    redirect = 1'b1;
    #1;
    check("rst_flush_ifid_follows", 32'(flush_ifid), 1);
    check("rst_flush_idex_follows", 32'(flush_idex), 1);
    redirect = 1'b0;

    // ---- ALU forwarding: add $3,$1,$2 ; sub $4,$3,$1 ; and $6,$3,$4 --------
    next_cycle();
    arst = 1'b0;
    drive_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);  // add $3
    #1;
    check("add_no_stall", 32'(stall), 0);

    next_cycle();                                               // EX = add
    drive_id(1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0);  // sub $4,$3,$1
    #1;
    check("add_ex_rs_sel", 32'(fwd_rs_sel), 0);
    check("add_ex_rt_sel", 32'(fwd_rt_sel), 0);

    next_cycle();                                               // EX = sub, MEM = add
    drive_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0);  // and $6,$3,$4
    #1;
    check("sub_rs_from_mem", 32'(fwd_rs_sel), 1);
    check("sub_rt_none", 32'(fwd_rt_sel), 0);

    next_cycle();                                               // EX = and, MEM = sub, WB = add
    drive_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);  // lw $5,0($1)
    #1;
    check("and_rs_from_wb", 32'(fwd_rs_sel), 2);
    check("and_rt_from_mem", 32'(fwd_rt_sel), 1);
    check("lw_id_no_stall", 32'(stall), 0);

    // ---- load-use: lw $5 ; add $6,$5,$5 -----------------------------------
    next_cycle();                                               // EX = lw $5
    drive_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    check("load_use_stall", 32'(stall), 1);
    check("load_use_cnt_before", 32'(stall_cnt), 0);

    next_cycle();                                               // EX = bubble, MEM = lw, add held
    #1;
    check("load_use_one_bubble", 32'(stall), 0);
    check("load_use_cnt_after", 32'(stall_cnt), 1);
    check("bubble_ex_rs_sel", 32'(fwd_rs_sel), 0);
    check("bubble_ex_rt_sel", 32'(fwd_rt_sel), 0);

    // The add reaches EX as the load moves into WB (stage 2).
    next_cycle();
    drive_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);  // lw $0,0($1)
    #1;
    check("load_fwd_rs", 32'(fwd_rs_sel), 2);
    check("load_fwd_rt", 32'(fwd_rt_sel), 2);
    check("load_fwd_no_stall", 32'(stall), 0);

    // ---- $0 is never a hazard ---------------------------------------------
    next_cycle();                                               // EX = lw $0
    drive_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);  // add $8,$0,$0
    #1;
    check("r0_no_stall", 32'(stall), 0);

    next_cycle();                                               // EX = add $8, MEM = lw $0
    drive_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);  // addi $7,$1
    #1;
    check("r0_rs_sel", 32'(fwd_rs_sel), 0);
    check("r0_rt_sel", 32'(fwd_rt_sel), 0);

    // ---- two writers to $7: youngest wins; unused rt never forwards -------
    next_cycle();
    drive_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);  // addi $7,$2
    next_cycle();
    drive_id(1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd9, 1'b1, 1'b0);  // ori $9,$7 (rt unused)
    next_cycle();                                               // EX = ori, MEM = $7b, WB = $7a
    drive_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1); // lw $10
    #1;
    check("youngest_wins", 32'(fwd_rs_sel), 1);
    check("rt_unused_no_fwd", 32'(fwd_rt_sel), 0);

    // ---- load-use coinciding with a redirect ------------------------------
    next_cycle();                                               // EX = lw $10
    drive_id(1'b1, 5'd10, 1'b1, 5'd0, 1'b1, 5'd11, 1'b1, 1'b0); // add $11,$10,$0
    redirect = 1'b1;
    #1;
    check("redirect_beats_stall", 32'(stall), 0);
    check("redirect_flush_ifid", 32'(flush_ifid), 1);
    check("redirect_flush_idex", 32'(flush_idex), 1);

    next_cycle();                                               // EX, MEM both bubbles
    redirect = 1'b0;
    drive_id(1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 5'd12, 1'b1, 1'b0); // sub $12,$10,$11
    #1;
    check("flush_cnt_one", 32'(flush_cnt), 1);
    check("flush_released", 32'(flush_ifid), 0);
    check("stall_cnt_unchanged", 32'(stall_cnt), 1);
    check("killed_load_no_stall", 32'(stall), 0);

    // Neither the killed lw nor the squashed add may be visible to sub.
    next_cycle();
    bubble_id();
    #1;
    check("after_redirect_rs_sel", 32'(fwd_rs_sel), 0);
    check("after_redirect_rt_sel", 32'(fwd_rt_sel), 0);

    // ---- counter saturation (CNT_W = 3, starts at 1, 8 more stalls) -------
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      drive_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1); // lw $5
      next_cycle();
      drive_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0); // add $6,$5
      #1;
      check($sformatf("sat_loop_stall_%0d", i), 32'(stall), 1);
      next_cycle();                                              // add held one cycle
    end
    next_cycle();
    bubble_id();
    #1;
    check("stall_cnt_saturated", 32'(stall_cnt), 7);

    redirect = 1'b1;
    for (int i = 0; i < 8; i++) next_cycle();
    redirect = 1'b0;
    #1;
    check("flush_cnt_saturated", 32'(flush_cnt), 7);

    // ---- reset clears counters; enable low freezes a stall ----------------
    next_cycle();
    arst = 1'b1;
    #1;
    check("rearst_stall_cnt", 32'(stall_cnt), 0);
    check("rearst_flush_cnt", 32'(flush_cnt), 0);
    next_cycle();
    arst = 1'b0;
    drive_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);  // lw $5
    next_cycle();
    drive_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);  // add $6,$5,$5
    enable = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    check("frozen_stall_held", 32'(stall), 1);
    check("frozen_stall_cnt", 32'(stall_cnt), 0);

    // Asynchronous reset mid-cycle, mid-stall, with the pipeline frozen.
    #2;
    arst = 1'b1;
    #1;
    check("arst_mid_stall_stall", 32'(stall), 0);
    check("arst_mid_stall_rs_sel", 32'(fwd_rs_sel), 0);
    check("arst_mid_stall_cnt", 32'(stall_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
